regfile_scoreboard: RTL

//  Parametrised integer register file, next generation of the core's register bank.
//  - Two combinational read ports, one write port, one debug read port.
//  - Per-register busy scoreboard so the pipeline can hold issue while a multi-cycle producer is outstanding.
//  - Sits between decode (reads, reservations) and writeback (writes, busy release).

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_scoreboard_sb.sv | 52 +++++
 rtl/regfile_scoreboard.sv | 77 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and width helpers for the register file
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int REG_ZERO  = 0;

    // Address width; a 1-bit floor keeps degenerate sizes legal
    function automatic int rf_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    function automatic int rf_cw(input int nregs);
        return $clog2(nregs + 1);
    endfunction

endpackage

// File: rtl/regfile_scoreboard_sb.sv
// rtl/regfile_scoreboard_sb.sv - busy vector, flush/reserve/release priority, busy counter
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = rf_aw(NREGS),
    parameter int CW    = rf_cw(NREGS)
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             FLUSH,
    input  logic             RSV_EN,
    input  logic [AW-1:0]    RSV_A,
    input  logic             WE3,
    input  logic [AW-1:0]    A3,
    output logic [NREGS-1:0] busy_vec,
    output logic [CW-1:0]    BUSY_CNT
);

    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic             inc;
    logic             dec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (RSV_EN && RSV_A != AW'(REG_ZERO)) set_vec[RSV_A] = 1'b1;
        if (WE3 && A3 != AW'(REG_ZERO))       clr_vec[A3]    = 1'b1;
    end

    // A reservation on the register being written wins, so that release is suppressed
    assign inc = |(set_vec & ~busy_vec);
    assign dec = |(clr_vec & busy_vec & ~set_vec);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            busy_vec <= '0;
            BUSY_CNT <= '0;
        end else if (FLUSH) begin
            busy_vec <= '0;
            BUSY_CNT <= '0;
        end else begin
            busy_vec <= (busy_vec & ~clr_vec) | set_vec;
            if (inc && !dec)
                BUSY_CNT <= BUSY_CNT + CW'(1);
            else if (dec && !inc)
                BUSY_CNT <= BUSY_CNT - CW'(1);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2R/1W register file with busy scoreboard and debug port
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter bit BYPASS = 1'b1,
    parameter int AW     = rf_aw(NREGS),
    parameter int CW     = rf_cw(NREGS)
) (
    input  logic            CLK,
    input  logic            reset_n,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            BUSY1,
    output logic            BUSY2,
    input  logic [AW-1:0]   A3,
    input  logic            WE3,
    input  logic [XLEN-1:0] WD3,
    input  logic            RSV_EN,
    input  logic [AW-1:0]   RSV_A,
    input  logic            FLUSH,
    output logic [CW-1:0]   BUSY_CNT,
    input  logic [AW-1:0]   DBG_A,
    output logic [XLEN-1:0] DBG_RD
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_vec;
    logic             wr_act;
    logic             byp1;
    logic             byp2;

    assign wr_act = WE3 && (A3 != AW'(REG_ZERO));

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_act) begin
            regs[A3] <= WD3;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .CW    (CW)
    ) u_sb (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .FLUSH    (FLUSH),
        .RSV_EN   (RSV_EN),
        .RSV_A    (RSV_A),
        .WE3      (WE3),
        .A3       (A3),
        .busy_vec (busy_vec),
        .BUSY_CNT (BUSY_CNT)
    );

    // wr_act already excludes x0, so a bypass hit never targets x0
    assign byp1 = BYPASS && wr_act && (A3 == A1);
    assign byp2 = BYPASS && wr_act && (A3 == A2);

    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (A1 != AW'(REG_ZERO)) RD1 = byp1 ? WD3 : regs[A1];
        if (A2 != AW'(REG_ZERO)) RD2 = byp2 ? WD3 : regs[A2];
    end

    assign BUSY1  = busy_vec[A1] && !byp1;
    assign BUSY2  = busy_vec[A2] && !byp2;
    assign DBG_RD = regs[DBG_A];

endmodule
